vga_sync_gen: RTL and testbench

- Raster timing generator that consumes the pixel-rate square wave from the clock-divider stage, for example 25 MHz derived from the 100 MHz system clock.
- Detects each rising edge of that wave, then uses it as a single-cycle pixel enable to advance horizontal and vertical counters in the system clock domain.
- Produces registered hsync, vsync, video_on, pixel coordinates and a frame-start pulse for the downstream pixel/colour logic.

---
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: edge-detects the divided pixel wave and
// advances h/v counters, producing registered sync, blanking and coordinates.
module vga_sync_gen #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_wave,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             pix_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic             wave_d;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             hs_next;
  logic             vs_next;
  logic             vo_next;
  logic             fs_next;

  // wave_d resets high so an already-high wave cannot fake an edge
  assign pix_tick = pix_wave & ~wave_d;

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (pix_tick) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        if (v_count == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = v_count + CNT_W'(1);
        end
      end else begin
        h_next = h_count + CNT_W'(1);
      end
    end
  end

  // Outputs decode the next counts so they line up with pixel_x/pixel_y
  always_comb begin
    hs_next = ~SYNC_ACTIVE;
    vs_next = ~SYNC_ACTIVE;
    if (h_next >= HS_FIRST && h_next <= HS_LAST) begin
      hs_next = SYNC_ACTIVE;
    end
    if (v_next >= VS_FIRST && v_next <= VS_LAST) begin
      vs_next = SYNC_ACTIVE;
    end
    vo_next = (h_next < H_VIS) && (v_next < V_VIS);
    fs_next = pix_tick && (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wave_d      <= 1'b1;
      h_count     <= H_LAST;
      v_count     <= V_LAST;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      wave_d      <= pix_wave;
      frame_start <= fs_next;
      if (pix_tick) begin
        h_count  <= h_next;
        v_count  <= v_next;
        hsync    <= hs_next;
        vsync    <= vs_next;
        video_on <= vo_next;
      end
    end
  end

  assign pixel_x = h_count;
  assign pixel_y = v_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small raster geometry, randomized pixel wave,
// raster-index reference model and a queue-based scoreboard.
module tb_vga_sync_gen;

  localparam int   HD = 20;
  localparam int   HF = 4;
  localparam int   HS = 6;
  localparam int   HB = 5;
  localparam int   VD = 10;
  localparam int   VF = 3;
  localparam int   VS = 2;
  localparam int   VB = 4;
  localparam logic SA = 1'b0;
  localparam int   CW = 10;
  localparam int   HT = HD + HF + HS + HB;
  localparam int   VT = VD + VF + VS + VB;
  localparam int   FT = HT * VT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_wave = 1'b0;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_start;
  logic          pix_tick;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pix_wave(pix_wave),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .pix_tick(pix_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    bit tick;
    bit newpix;
    int x;
    int y;
    bit hs;
    bit vs;
    bit vo;
    bit fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   cnt_en = 0;
  int   vs_cnt = 0;
  int   vo_cnt = 0;
  int   fs_cnt = 0;

  // reference model: linear raster index plus last wave level
  bit known = 0;
  bit prevw = 1;
  int idx = 0;
  bit m_new = 0;
  bit m_hs, m_vs, m_vo, m_fs;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit w, input bit r);
    exp_t e;
    bit   t;
    int   x, y;
    @(posedge clk);
    #1;
    pix_wave = w;
    reset    = r;
    t        = w & ~prevw;
    e.chk    = known;
    e.tick   = t;
    e.newpix = m_new;
    e.x      = idx % HT;
    e.y      = idx / HT;
    e.hs     = m_hs;
    e.vs     = m_vs;
    e.vo     = m_vo;
    e.fs     = m_fs;
    q.push_back(e);
    if (r) begin
      known = 1;
      prevw = 1;
      idx   = FT - 1;
      m_hs  = ~SA;
      m_vs  = ~SA;
      m_vo  = 0;
      m_fs  = 0;
      m_new = 0;
    end else begin
      prevw = w;
      m_new = t;
      m_fs  = 0;
      if (t) begin
        idx  = (idx + 1) % FT;
        x    = idx % HT;
        y    = idx / HT;
        m_hs = (x >= HD + HF && x < HD + HF + HS) ? SA : ~SA;
        m_vs = (y >= VD + VF && y < VD + VF + VS) ? SA : ~SA;
        m_vo = (x < HD) && (y < VD);
        m_fs = (idx == 0);
      end
    end
  endtask

  task automatic hold(input int n, input bit w);
    for (int i = 0; i < n; i++) step(w, 0);
  endtask

  task automatic tick_run(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      hold(half, 0);
      hold(half, 1);
    end
  endtask

  task automatic rand_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hold($urandom_range(1, 3), 0);
      hold($urandom_range(1, 3), 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        chk("pix_tick", 32'(pix_tick), 32'(e.tick));
        chk("pixel_x", 32'(pixel_x), 32'(e.x));
        chk("pixel_y", 32'(pixel_y), 32'(e.y));
        chk("hsync", 32'(hsync), 32'(e.hs));
        chk("vsync", 32'(vsync), 32'(e.vs));
        chk("video_on", 32'(video_on), 32'(e.vo));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        if (cnt_en && e.newpix) begin
          vs_cnt += (vsync == SA) ? 1 : 0;
          vo_cnt += video_on ? 1 : 0;
          fs_cnt += frame_start ? 1 : 0;
        end
      end
    end
  end

  initial begin
    int n;
    // reset, then period-4 wave through the end of line 0 and into line 1
    repeat (3) step(0, 1);
    tick_run(HT + 5, 2);

    // one full frame of ticks with jittered wave timing
    hold(3, 1);
    cnt_en = 1;
    rand_ticks(FT);
    hold(3, 1);
    cnt_en = 0;
    chk("frame_vsync_ticks", 32'(vs_cnt), 32'(VS * HT));
    chk("frame_video_ticks", 32'(vo_cnt), 32'(HD * VD));
    chk("frame_start_count", 32'(fs_cnt), 32'(1));

    // constant wave mid-line
    tick_run(7, 1);
    hold(50, 1);
    hold(50, 0);

    // reset mid-frame at pixel (12,5)
    n = (5 * HT + 12 - idx + FT) % FT;
    tick_run(n, 2);
    step(0, 1);
    tick_run(3, 2);

    // release reset with the wave already high
    step(1, 1);
    step(1, 1);
    hold(3, 1);
    hold(2, 0);
    hold(2, 1);

    // free-running random wave with occasional reset
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), ($urandom_range(0, 999) == 0));
    end
    rand_ticks(FT + 40);

    hold(3, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
